// File: rtl/apb_master_bridge.sv
// apb_master_bridge: FIFO-buffered valid/ready requests driven over APB (pclk/preset), one response per request with pready timeout
module apb_master_bridge #(
  parameter int ADDR       = 10,
  parameter int DATA       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_write,
  output logic            rsp_err,
  output logic [DATA-1:0] rsp_rdata,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [ADDR-1:0] paddr,
  output logic [DATA-1:0] pwdata,
  input  logic            pready,
  input  logic [DATA-1:0] prdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int EW = 1 + ADDR + DATA;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic [TW-1:0] wait_cnt;
  logic          empty, push, pop;
  assign head      = mem[rp];
  assign empty     = cnt == '0;
  assign req_ready = !preset && cnt != (PW+1)'(FIFO_DEPTH);
  assign push      = req_valid && req_ready;
  assign pop       = !empty && (state == IDLE || (state == ACCESS && pready));
  always_ff @(posedge pclk) begin
    if (push) mem[wp] <= {req_write, req_addr, req_wdata};
    if (preset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: {psel, penable} <= 2'b00;
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (pready || wait_cnt == TW'(TIMEOUT - 1)) begin
            rsp_valid       <= 1'b1;
            rsp_err         <= !pready;
            rsp_write       <= pwrite;
            rsp_rdata       <= (pready && !pwrite) ? prdata : '0;
            {psel, penable} <= 2'b00;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // a pop always launches the head request into SETUP, overriding the IDLE/ACCESS defaults above
      if (pop) begin
        paddr   <= head[DATA +: ADDR];
        pwrite  <= head[EW-1];
        pwdata  <= head[EW-1] ? head[DATA-1:0] : '0;
        psel    <= 1'b1;
        penable <= 1'b0;
        state   <= SETUP;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scenario tests of apb_master_bridge against a simple APB memory model
module tb_apb_master_bridge;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        stall = 1'b0;
  logic        trace_on = 1'b0;
  logic [31:0] smem [1024];
  logic [33:0] rsp_q [$];
  logic [2:0]  tr_q [$];
  logic [79:0] all_outs;
  int          checks = 0;
  int          failures = 0;

  apb_master_bridge dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;
  assign pready   = !stall;
  assign prdata   = smem[paddr];
  assign all_outs = {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_write, rsp_rdata};

  always @(posedge pclk) if (psel && penable && pready && pwrite) smem[paddr] <= pwdata;

  always @(negedge pclk) begin
    if (rsp_valid) rsp_q.push_back({rsp_write, rsp_err, rsp_rdata});
    if (trace_on) tr_q.push_back({psel, penable, rsp_valid});
  end

  task automatic push(input logic w, input logic [9:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_accept addr=%h got_ready=%b exp=1", a, req_ready);
    end
    @(negedge pclk);
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 200) begin
      @(negedge pclk);
      k++;
    end
    @(negedge pclk);
    checks++;
    if (rsp_q.size() != n) begin
      failures++;
      $display("FAIL rsp_count got=%0d exp=%0d", rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pclk);
    checks++;
    if (all_outs !== 80'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    preset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_single();
    @(negedge pclk);
    stall = 1'b0;
    rsp_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h005; req_wdata = 32'hDEADBEEF;
    @(negedge pclk);
    req_write = 1'b0; req_wdata = '0;
    checks++;
    if (psel !== 1'b0) begin failures++; $display("FAIL lat_n_psel got=%b exp=0", psel); end
    @(negedge pclk);
    req_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 10'h005, 32'hDEADBEEF}) begin
      failures++; $display("FAIL lat_n1_setup got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 10'h005, 32'hDEADBEEF});
    end
    @(negedge pclk);
    checks++;
    if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL lat_n2_access got=%b exp=11", {psel, penable}); end
    @(negedge pclk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata} !== {3'b101, 32'h0}) begin
      failures++; $display("FAIL single_wr_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_write, rsp_rdata}, {3'b101, 32'h0});
    end
    @(negedge pclk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid); end
    @(negedge pclk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL single_rd_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_write, rsp_rdata}, {3'b100, 32'hDEADBEEF});
    end
    @(negedge pclk);
    checks++;
    if ({rsp_valid, psel, rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rsp_hold got=%h exp=%h", {rsp_valid, psel, rsp_rdata}, {2'b00, 32'hDEADBEEF});
    end
  endtask

  task automatic test_fill();
    @(negedge pclk);
    rsp_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 10'(32'h020 + i), 32'h0);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", req_ready); end
    checks++;
    if ({psel, penable, paddr} !== {2'b11, 10'h020}) begin
      failures++; $display("FAIL fill_stall got=%h exp=%h", {psel, penable, paddr}, {2'b11, 10'h020});
    end
    stall = 1'b0;
    wait_rsp(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_q[i] !== {2'b00, 32'(32'h10000020 + i)}) begin
        failures++; $display("FAIL fill_rsp%0d got=%h exp=%h", i, rsp_q[i], {2'b00, 32'(32'h10000020 + i)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int f;
    @(negedge pclk);
    rsp_q.delete();
    tr_q.delete();
    trace_on = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 10'(32'h3F8 + i), 32'(32'hB0B00000 + i));
    req_valid = 1'b0;
    wait_rsp(8);
    trace_on = 1'b0;
    f = -1;
    for (int k = 0; k < tr_q.size(); k++) if (f < 0 && tr_q[k][2]) f = k;
    checks++;
    if (f < 0) begin failures++; $display("FAIL b2b_psel_seen got=0 exp=1"); f = 0; end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tr_q[f+k][2:1] !== {1'b1, k[0]}) begin
        failures++; $display("FAIL b2b_apb%0d got=%b exp=%b", k, tr_q[f+k][2:1], {1'b1, k[0]});
      end
    end
    checks++;
    if (tr_q[f+16][2] !== 1'b0) begin failures++; $display("FAIL b2b_end_psel got=%b exp=0", tr_q[f+16][2]); end
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (tr_q[f+2+k][0] !== !k[0]) begin
        failures++; $display("FAIL b2b_rsp%0d got=%b exp=%b", k, tr_q[f+2+k][0], !k[0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_q[i] !== {2'b10, 32'h0}) begin failures++; $display("FAIL b2b_wr%0d got=%h exp=%h", i, rsp_q[i], {2'b10, 32'h0}); end
    end
    rsp_q.delete();
    for (int i = 0; i < 8; i++) push(1'b0, 10'(32'h3F8 + i), 32'h0);
    req_valid = 1'b0;
    wait_rsp(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_q[i] !== {2'b00, 32'(32'hB0B00000 + i)}) begin
        failures++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, rsp_q[i], {2'b00, 32'(32'hB0B00000 + i)});
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int c;
    @(negedge pclk);
    rsp_q.delete();
    stall = 1'b1;
    push(1'b0, 10'h010, 32'h0);
    push(1'b1, 10'h011, 32'h55);
    req_valid = 1'b0;
    n = 0;
    while (!penable && n < 50) begin @(negedge pclk); n++; end
    c = 0;
    while (!rsp_valid && c < 40) begin @(negedge pclk); c++; end
    checks++;
    if (c != 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", c); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata, psel} !== {3'b110, 32'h0, 1'b0}) begin
      failures++; $display("FAIL to_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_write, rsp_rdata, psel}, {3'b110, 32'h0, 1'b0});
    end
    stall = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel, penable, paddr} !== {2'b10, 10'h011}) begin
      failures++; $display("FAIL to_next got=%h exp=%h", {psel, penable, paddr}, {2'b10, 10'h011});
    end
    wait_rsp(2);
    checks++;
    if (rsp_q[0] !== {2'b01, 32'h0}) begin failures++; $display("FAIL to_q0 got=%h exp=%h", rsp_q[0], {2'b01, 32'h0}); end
    checks++;
    if (rsp_q[1] !== {2'b10, 32'h0}) begin failures++; $display("FAIL to_q1 got=%h exp=%h", rsp_q[1], {2'b10, 32'h0}); end
    checks++;
    if (smem[10'h011] !== 32'h55) begin failures++; $display("FAIL to_wr_mem got=%h exp=55", smem[10'h011]); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge pclk);
    rsp_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 10'(32'h030 + i), 32'h0);
    req_valid = 1'b0;
    n = 0;
    while (!penable && n < 50) begin @(negedge pclk); n++; end
    preset = 1'b1;
    @(negedge pclk);
    checks++;
    if (all_outs !== 80'h0) begin failures++; $display("FAIL mid_outs got=%h exp=0", all_outs); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", req_ready); end
    @(negedge pclk);
    checks++;
    if (all_outs !== 80'h0) begin failures++; $display("FAIL mid_hold got=%h exp=0", all_outs); end
    preset = 1'b0;
    stall = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b exp=1", req_ready); end
    repeat (10) @(negedge pclk);
    checks++;
    if (rsp_q.size() != 0) begin failures++; $display("FAIL mid_dropped got=%0d exp=0", rsp_q.size()); end
    push(1'b0, 10'h005, 32'h0);
    req_valid = 1'b0;
    wait_rsp(1);
    checks++;
    if (rsp_q[0] !== {2'b00, 32'hDEADBEEF}) begin
      failures++; $display("FAIL mid_read got=%h exp=%h", rsp_q[0], {2'b00, 32'hDEADBEEF});
    end
  endtask

  task automatic test_wrap();
    @(negedge pclk);
    rsp_q.delete();
    for (int i = 0; i < 10; i++) push(1'b1, 10'(32'h200 + i), 32'(32'hC0DE0000 + i));
    for (int i = 0; i < 10; i++) push(1'b0, 10'(32'h200 + i), 32'h0);
    req_valid = 1'b0;
    wait_rsp(20);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_q[i] !== {2'b10, 32'h0}) begin failures++; $display("FAIL wrap_wr%0d got=%h exp=%h", i, rsp_q[i], {2'b10, 32'h0}); end
      checks++;
      if (rsp_q[10+i] !== {2'b00, 32'(32'hC0DE0000 + i)}) begin
        failures++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, rsp_q[10+i], {2'b00, 32'(32'hC0DE0000 + i)});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) smem[i] = 32'(32'h10000000 + i);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that drives the APB memory slave on the same `pclk` domain. It accepts read/write requests from an internal valid/ready port and buffers them in a small FIFO. It runs each request through the APB SETUP/ACCESS protocol and returns one response per request, carrying read data or a timeout error. It sits directly upstream of the memory slave and is the only master on that APB segment.

## Interface
- `ADDR`, 10, APB address width; matches the slave's `ADDR`.
- `DATA`, 32, data width.
- `FIFO_DEPTH`, 4, request FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT`, 16, maximum ACCESS cycles waiting for `pready` before abort; ≥2.

Ports:
- `pclk` in 1: sole clock; all logic is on its rising edge.
- `preset` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request FIFO can accept. Equals `!full`, and is forced 0 while `preset`=1.
- `req_write` in 1: 1 for write, 0 for read.
- `req_addr` in ADDR: target address.
- `req_wdata` in DATA: write data; ignored for reads.
- `rsp_valid` out 1: single-cycle pulse, one per completed request.
- `rsp_write` out 1: echoes `req_write` of the completed request.
- `rsp_err` out 1: 1 means the transfer timed out.
- `rsp_rdata` out DATA: read data. It is 0 for writes and for errors.
- `psel`, `penable`, `pwrite` out 1: APB controls.
- `paddr` out ADDR, `pwdata` out DATA: APB address and write data.
- `pready` in 1, `prdata` in DATA: APB slave response.

## Operation
- **Reset.** All outputs are 0, the FIFO is empty, and the FSM is in IDLE.
- **Request FIFO.**
  - A push happens when `req_valid && req_ready`. The FSM pops the FIFO.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged. Data pushed at a wrap boundary must be preserved.
  - A push when full cannot occur, because `req_ready`=0.
- **FSM states.** IDLE, SETUP, ACCESS.
- **IDLE.**
  - If the FIFO is non-empty: pop the head and register `paddr`, `pwrite` and `pwdata` (`pwdata`=0 for reads). Set `psel`=1 and `penable`=0, then go to SETUP.
  - Otherwise keep `psel`=`penable`=0.
- **SETUP.** Set `penable`=1, clear the wait counter, and go to ACCESS.
- **ACCESS with `pready`=1:**
  - Register the response: `rsp_valid`=1, `rsp_err`=0, `rsp_write`=`pwrite`, and `rsp_rdata`=`prdata` for a read or 0 for a write.
  - If the FIFO is non-empty, pop the next request and go straight to SETUP. `psel` stays 1, `penable`=0, and `paddr`/`pwrite`/`pwdata` are updated.
  - Otherwise go to IDLE with `psel`=`penable`=0.
- **ACCESS with `pready`=0.**
  - `paddr`, `pwrite`, `pwdata`, `psel` and `penable` hold stable.
  - The wait counter (log2(TIMEOUT)+1 bits) increments.
  - When the counter equals TIMEOUT-1 and `pready` is still 0, abort:
    - `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0;
    - go to IDLE with `psel`=`penable`=0 for at least one cycle, even if the FIFO is non-empty.
- **Response pulse.** `rsp_valid` is high for exactly one cycle per response. `rsp_rdata`, `rsp_err` and `rsp_write` hold their value until the next response.
- **Ordering.** Responses are returned in request order, and no request is dropped.

## Timing
- **Latency.**
  - A request pushed at edge N with an empty FIFO and FSM in IDLE gives `psel`=1 after N+1 and `penable`=1 after N+2.
  - With `pready`=1, `rsp_valid`=1 in the cycle after edge N+3.
- **Throughput.** Back-to-back transfers take 2 cycles each, so `rsp_valid` pulses every 2nd cycle while the FIFO stays non-empty.
- **Timeout.** With `pready` stuck at 0, `rsp_valid`/`rsp_err` rise TIMEOUT cycles after `penable` rose.
- **Reset mid-transfer.** `preset`=1 at any edge returns everything to the reset state on that edge. All queued requests are discarded and no response is issued for them.
- **Response vs. push.** A response and a push in the same cycle are independent.

## Test plan
- **Single write/read.** After reset, write addr 0x005 data 0xDEADBEEF, then read 0x005. Expect two `rsp_valid` pulses: write with `rsp_rdata`=0, read with `rsp_rdata`=0xDEADBEEF. Latency 3 edges from the first push.
- **Fill FIFO.** Push 5 requests with the downstream slave stalled (`pready`=0 in ACCESS).
  - `req_ready` drops after 4 entries held: FIFO_DEPTH=4, with 1 request in flight.
  - After release, all 5 responses arrive in order.
- **Back-to-back.** 8 writes to 0x3F8..0x3FF, pushed continuously. Expect `psel` continuously 1 and `penable` toggling 0,1,0,1. Reads back return the written values.
- **Timeout.** Hold `pready`=0 for a read of 0x010. Expect `rsp_err`=1 and `rsp_rdata`=0 after 16 ACCESS cycles, and `psel`=0 for one cycle before the next queued request.
- **Reset mid-operation.** Queue 3 requests and assert `preset` during the ACCESS of the first.
  - Next cycle: all outputs 0, `req_ready`=0 while reset is held, and no `rsp_valid`.
  - After release, `req_ready`=1 and a new read of 0x005 completes normally.
- **Pointer wrap.** Issue 10 sequential requests across FIFO wrap with simultaneous push/pop. All data is intact and in order.
